// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, even parity, 1 stop bit, mid-bit sampling.
// Latency: strobe one cycle after the mid stop-bit sample; no backpressure, so each byte must be taken on RX_valid.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX_data_in,
    output logic [7:0] RX_data_out,
    output logic       RX_valid,
    output logic       RX_busy,
    output logic       RX_parity_err,
    output logic       RX_frame_err
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state_q, state_d;
    logic             s1_q, s1_d, s2_q, s2_d, s2_prev_q, s2_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_bit_q, par_bit_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             parity_err_q, parity_err_d;
    logic             frame_err_q, frame_err_d;

    always_comb begin
        s1_d         = RX_data_in;
        s2_d         = s1_q;
        s2_prev_d    = s2_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        busy_d       = busy_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        case (state_q)
            IDLE: begin
                // Edge-based start so a stuck-low line cannot retrigger
                if (!s2_q && s2_prev_q) begin
                    state_d = START;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    if (s2_q) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {s2_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    par_bit_d = s2_q;
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is not missed
                if (cnt_q == CNT_LAST) begin
                    cnt_d        = '0;
                    data_d       = shift_q;
                    parity_err_d = par_bit_q ^ (^shift_q);
                    frame_err_d  = !s2_q;
                    valid_d      = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            s1_q         <= 1'b1;
            s2_q         <= 1'b1;
            s2_prev_q    <= 1'b1;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            par_bit_q    <= 1'b0;
            data_q       <= 8'h00;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s2_prev_q    <= s2_prev_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign RX_data_out   = data_q;
    assign RX_valid      = valid_q;
    assign RX_busy       = busy_q;
    assign RX_parity_err = parity_err_q;
    assign RX_frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=16; edge numbers are relative to the first edge seeing the start bit.
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       RX_data_in;
    logic [7:0] RX_data_out;
    logic       RX_valid;
    logic       RX_busy;
    logic       RX_parity_err;
    logic       RX_frame_err;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int t0 = 0;
    int valid_cnt = 0;
    int valid_cyc = 0;
    int prev_valid_cyc = 0;
    int busy_rise_cyc = 0;
    int busy_fall_cyc = 0;
    logic busy_prev = 1'b0;
    int saved_cnt;

    uart_rx #(.CLKS_PER_BIT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .RX_data_in   (RX_data_in),
        .RX_data_out  (RX_data_out),
        .RX_valid     (RX_valid),
        .RX_busy      (RX_busy),
        .RX_parity_err(RX_parity_err),
        .RX_frame_err (RX_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // After edge k, cyc == t0 + k + 1, so recorded values map back to edge numbers
    always @(negedge clk) begin
        if (RX_valid) begin
            valid_cnt      = valid_cnt + 1;
            prev_valid_cyc = valid_cyc;
            valid_cyc      = cyc;
        end
        if (RX_busy && !busy_prev) busy_rise_cyc = cyc;
        if (!RX_busy && busy_prev) busy_fall_cyc = cyc;
        busy_prev = RX_busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives the first n frame bits (bit 0 = start); caller must be just after an edge
    task automatic send_bits(input logic [10:0] bits, input int n);
        t0 = cyc;
        for (int k = 0; k < n; k++) begin
            RX_data_in = bits[k];
            wait_edges(16);
        end
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d, input logic par, input logic stp);
        return {stp, par, d, 1'b0};
    endfunction

    initial begin
        rst = 1'b1;
        RX_data_in = 1'b1;
        wait_edges(3);
        check("reset_data", 32'(RX_data_out), 32'h00);
        check("reset_valid", 32'(RX_valid), 32'h0);
        check("reset_busy", 32'(RX_busy), 32'h0);
        check("reset_perr", 32'(RX_parity_err), 32'h0);
        check("reset_ferr", 32'(RX_frame_err), 32'h0);
        rst = 1'b0;
        wait_edges(10);

        // Nominal 0xA5, even parity 0
        saved_cnt = valid_cnt;
        send_bits(frame(8'hA5, 1'b0, 1'b1), 11);
        RX_data_in = 1'b1;
        check("a5_strobes", 32'(valid_cnt - saved_cnt), 32'd1);
        check("a5_valid_edge", 32'(valid_cyc - t0 - 1), 32'd170);
        check("a5_busy_rise", 32'(busy_rise_cyc - t0 - 1), 32'd2);
        check("a5_busy_fall", 32'(busy_fall_cyc - t0 - 1), 32'd170);
        check("a5_data", 32'(RX_data_out), 32'hA5);
        check("a5_perr", 32'(RX_parity_err), 32'h0);
        check("a5_ferr", 32'(RX_frame_err), 32'h0);
        wait_edges(20);

        // 0x01 needs parity 1; send 0
        send_bits(frame(8'h01, 1'b0, 1'b1), 11);
        RX_data_in = 1'b1;
        check("p01_data", 32'(RX_data_out), 32'h01);
        check("p01_perr", 32'(RX_parity_err), 32'h1);
        check("p01_ferr", 32'(RX_frame_err), 32'h0);
        wait_edges(20);

        // 0x3C with low stop bit, then a 40-bit break
        saved_cnt = valid_cnt;
        send_bits(frame(8'h3C, 1'b0, 1'b0), 11);
        check("f3c_data", 32'(RX_data_out), 32'h3C);
        check("f3c_ferr", 32'(RX_frame_err), 32'h1);
        check("f3c_perr", 32'(RX_parity_err), 32'h0);
        wait_edges(40 * 16);
        check("break_strobes", 32'(valid_cnt - saved_cnt), 32'd1);
        check("break_busy", 32'(RX_busy), 32'h0);
        RX_data_in = 1'b1;
        wait_edges(32);
        check("break_release_strobes", 32'(valid_cnt - saved_cnt), 32'd1);

        // 4-cycle glitch: busy over edges 2..10, no strobe, outputs held
        saved_cnt = valid_cnt;
        t0 = cyc;
        RX_data_in = 1'b0;
        wait_edges(4);
        RX_data_in = 1'b1;
        wait_edges(20);
        check("glitch_busy_rise", 32'(busy_rise_cyc - t0 - 1), 32'd2);
        check("glitch_busy_fall", 32'(busy_fall_cyc - t0 - 1), 32'd10);
        check("glitch_strobes", 32'(valid_cnt - saved_cnt), 32'd0);
        check("glitch_data", 32'(RX_data_out), 32'h3C);
        check("glitch_ferr", 32'(RX_frame_err), 32'h1);
        wait_edges(10);

        // Back-to-back 0x00 then 0xFF
        saved_cnt = valid_cnt;
        send_bits(frame(8'h00, 1'b0, 1'b1), 11);
        check("b2b0_data", 32'(RX_data_out), 32'h00);
        check("b2b0_perr", 32'(RX_parity_err), 32'h0);
        check("b2b0_ferr", 32'(RX_frame_err), 32'h0);
        send_bits(frame(8'hFF, 1'b0, 1'b1), 11);
        RX_data_in = 1'b1;
        check("b2b_strobes", 32'(valid_cnt - saved_cnt), 32'd2);
        check("b2b_spacing", 32'(valid_cyc - prev_valid_cyc), 32'd176);
        check("b2b1_data", 32'(RX_data_out), 32'hFF);
        check("b2b1_perr", 32'(RX_parity_err), 32'h0);
        check("b2b1_ferr", 32'(RX_frame_err), 32'h0);
        wait_edges(20);

        // Reset in the middle of data bit 4 of 0x55
        saved_cnt = valid_cnt;
        send_bits(frame(8'h55, 1'b0, 1'b1), 5);
        RX_data_in = 1'b1;
        wait_edges(8);
        check("mid_busy", 32'(RX_busy), 32'h1);
        rst = 1'b1;
        #1;
        check("rst_data", 32'(RX_data_out), 32'h00);
        check("rst_busy", 32'(RX_busy), 32'h0);
        check("rst_valid", 32'(RX_valid), 32'h0);
        check("rst_perr", 32'(RX_parity_err), 32'h0);
        check("rst_ferr", 32'(RX_frame_err), 32'h0);
        wait_edges(3);
        rst = 1'b0;
        wait_edges(20);
        check("rst_strobes", 32'(valid_cnt - saved_cnt), 32'd0);

        send_bits(frame(8'h96, 1'b0, 1'b1), 11);
        RX_data_in = 1'b1;
        check("r96_strobes", 32'(valid_cnt - saved_cnt), 32'd1);
        check("r96_valid_edge", 32'(valid_cyc - t0 - 1), 32'd170);
        check("r96_data", 32'(RX_data_out), 32'h96);
        check("r96_perr", 32'(RX_parity_err), 32'h0);
        check("r96_ferr", 32'(RX_frame_err), 32'h0);
        wait_edges(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
